// File: rtl/mult_pipe.sv
// Fully pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU) with a tag carried per operation.
// Optional in-flight kill via the squash port, compiled in with MULT_SQUASH_EN.
module mult_pipe #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NUM_STAGES = 4,
   parameter int unsigned TAG_WIDTH  = 6
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [XLEN-1:0]      mcand,
   input  logic [XLEN-1:0]      mplier,
   input  logic [1:0]           func,
   input  logic [TAG_WIDTH-1:0] tag_in,
`ifdef MULT_SQUASH_EN
   input  logic                 squash,
`endif
   output logic                 done,
   output logic [XLEN-1:0]      product,
   output logic [TAG_WIDTH-1:0] tag_out
);

   localparam int unsigned W2   = 2 * XLEN;
   localparam int unsigned CW   = W2 / NUM_STAGES;
   localparam int unsigned LAST = NUM_STAGES - 1;

   logic kill;
`ifdef MULT_SQUASH_EN
   assign kill = reset | squash;
`else
   assign kill = reset;
`endif

   logic          mc_sign;
   logic          mp_sign;
   logic [W2-1:0] ext_mc;
   logic [W2-1:0] ext_mp;

   assign mc_sign = ((func == 2'b01) || (func == 2'b10)) && mcand[XLEN-1];
   assign mp_sign = (func == 2'b01) && mplier[XLEN-1];
   assign ext_mc  = {{XLEN{mc_sign}}, mcand};
   assign ext_mp  = {{XLEN{mp_sign}}, mplier};

   logic [NUM_STAGES-1:0] st_valid;
   logic [W2-1:0]         st_sum  [NUM_STAGES];
   logic [W2-1:0]         st_mc   [NUM_STAGES];
   logic [W2-1:0]         st_mp   [NUM_STAGES];
   logic [1:0]            st_func [NUM_STAGES];
   logic [TAG_WIDTH-1:0]  st_tag  [NUM_STAGES];

   logic [NUM_STAGES-1:0] in_valid;
   logic [W2-1:0]         in_sum  [NUM_STAGES];
   logic [W2-1:0]         in_mc   [NUM_STAGES];
   logic [W2-1:0]         in_mp   [NUM_STAGES];
   logic [1:0]            in_func [NUM_STAGES];
   logic [TAG_WIDTH-1:0]  in_tag  [NUM_STAGES];

   // Stage 0 works directly on the extended operands, so chunk 0 is folded in at acceptance.
   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage_in
      if (g == 0) begin : g_first
         assign in_valid[g] = start;
         assign in_sum[g]   = '0;
         assign in_mc[g]    = ext_mc;
         assign in_mp[g]    = ext_mp;
         assign in_func[g]  = func;
         assign in_tag[g]   = tag_in;
      end else begin : g_rest
         assign in_valid[g] = st_valid[g-1];
         assign in_sum[g]   = st_sum[g-1];
         assign in_mc[g]    = st_mc[g-1];
         assign in_mp[g]    = st_mp[g-1];
         assign in_func[g]  = st_func[g-1];
         assign in_tag[g]   = st_tag[g-1];
      end
   end

   always_ff @(posedge clock) begin
      if (kill) begin
         st_valid <= '0;
      end else begin
         st_valid <= in_valid;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            st_sum[i]  <= '0;
            st_mc[i]   <= '0;
            st_mp[i]   <= '0;
            st_func[i] <= '0;
            st_tag[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            st_sum[i]  <= in_sum[i] + in_mc[i] * W2'(in_mp[i][CW-1:0]);
            st_mc[i]   <= in_mc[i] << CW;
            st_mp[i]   <= in_mp[i] >> CW;
            st_func[i] <= in_func[i];
            st_tag[i]  <= in_tag[i];
         end
      end
   end

   logic [XLEN-1:0] sel;
   assign sel = (st_func[LAST] == 2'b00) ? st_sum[LAST][XLEN-1:0] : st_sum[LAST][W2-1:XLEN];

   // Output register holds product/tag between completions; a squash edge also suppresses done.
   always_ff @(posedge clock) begin
      if (reset) begin
         done    <= 1'b0;
         product <= '0;
         tag_out <= '0;
      end else begin
         done <= st_valid[LAST] & ~kill;
         if (st_valid[LAST]) begin
            product <= sel;
            tag_out <= st_tag[LAST];
         end
      end
   end

endmodule

// File: tb/tb_mult_pipe.sv
// Directed bench for mult_pipe: four instances (NUM_STAGES 4, 1, 2, 8) share one stimulus stream,
// each checked every cycle against a per-cycle record of issued operations.
module tb_mult_pipe;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] mcand;
   logic [31:0] mplier;
   logic [1:0]  func;
   logic [5:0]  tag_in;
   logic        squash;

   logic [3:0]  done_o;
   logic [31:0] prod_o [4];
   logic [5:0]  tag_o  [4];

   int unsigned lat [4] = '{4, 1, 2, 8};

   int total = 0;
   int bad   = 0;
   int nxt   = 0;

   logic        hv [512];
   logic [31:0] hp [512];
   logic [5:0]  ht [512];

   always #5 clock = ~clock;

   mult_pipe u_s4 (
      .clock(clock), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
      .func(func), .tag_in(tag_in),
`ifdef MULT_SQUASH_EN
      .squash(squash),
`endif
      .done(done_o[0]), .product(prod_o[0]), .tag_out(tag_o[0]));

   mult_pipe #(.NUM_STAGES(1)) u_s1 (
      .clock(clock), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
      .func(func), .tag_in(tag_in),
`ifdef MULT_SQUASH_EN
      .squash(squash),
`endif
      .done(done_o[1]), .product(prod_o[1]), .tag_out(tag_o[1]));

   mult_pipe #(.NUM_STAGES(2)) u_s2 (
      .clock(clock), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
      .func(func), .tag_in(tag_in),
`ifdef MULT_SQUASH_EN
      .squash(squash),
`endif
      .done(done_o[2]), .product(prod_o[2]), .tag_out(tag_o[2]));

   mult_pipe #(.NUM_STAGES(8)) u_s8 (
      .clock(clock), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
      .func(func), .tag_in(tag_in),
`ifdef MULT_SQUASH_EN
      .squash(squash),
`endif
      .done(done_o[3]), .product(prod_o[3]), .tag_out(tag_o[3]));

   function automatic logic [31:0] model(input logic [1:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned p;
      sa = $signed(a);
      sb = $signed(b);
      ua = 64'(a);
      ub = 64'(b);
      case (f)
         2'b00:   p = ua * ub;
         2'b01:   p = sa * sb;
         2'b10:   p = sa * ub;
         default: p = ua * ub;
      endcase
      return (f == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic step();
      int src;
      logic ev;
      @(posedge clock);
      if (reset || squash) begin
         for (int k = nxt - 8; k <= nxt; k++)
            if (k >= 0) hv[k] = 1'b0;
      end
      #1;
      for (int d = 0; d < 4; d++) begin
         src = nxt - int'(lat[d]);
         ev  = (src >= 0) ? hv[src] : 1'b0;
         check($sformatf("done_s%0d_c%0d", lat[d], nxt), 32'(done_o[d]), 32'(ev));
         if (ev) begin
            check($sformatf("product_s%0d_tag%0d", lat[d], ht[src]), prod_o[d], hp[src]);
            check($sformatf("tag_s%0d_c%0d", lat[d], nxt), 32'(tag_o[d]), 32'(ht[src]));
         end
      end
      nxt++;
   endtask

   task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] t, input logic [31:0] e);
      start   = 1'b1;
      func    = f;
      mcand   = a;
      mplier  = b;
      tag_in  = t;
      hv[nxt] = 1'b1;
      hp[nxt] = e;
      ht[nxt] = t;
      step();
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      start = 1'b0;
      repeat (n) step();
   endtask

   task automatic check_cleared(input string name);
      for (int d = 0; d < 4; d++) begin
         check($sformatf("%s_product_s%0d", name, lat[d]), prod_o[d], 32'h0);
         check($sformatf("%s_tag_s%0d", name, lat[d]), 32'(tag_o[d]), 32'h0);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  f;
      for (int k = 0; k < 512; k++) hv[k] = 1'b0;
      reset = 1'b1; start = 1'b0; squash = 1'b0;
      mcand = '0; mplier = '0; func = '0; tag_in = '0;
      idle(2);
      check_cleared("reset_state");
      reset = 1'b0;

      // basic MUL
      issue(2'b00, 32'd2, 32'd3, 6'd5, 32'd6);
      idle(9);

      // all-ones operands, signed high halves, MULHSU
      issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1, 32'h00000000);
      issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2, 32'hFFFFFFFE);
      issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3, 32'h00000001);
      issue(2'b10, 32'hFFFFFFFF, 32'h00000002, 6'd4, 32'hFFFFFFFF);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 6'd6, 32'h80000000);

      // zero operands and wraparound
      issue(2'b01, 32'h00000000, 32'h80000000, 6'd7,  32'h0);
      issue(2'b11, 32'h12345678, 32'h00000000, 6'd8,  32'h0);
      issue(2'b10, 32'h00000000, 32'hFFFFFFFF, 6'd9,  32'h0);
      issue(2'b00, 32'h00000000, 32'hFFFFFFFF, 6'd10, 32'h0);
      issue(2'b00, 32'h00010000, 32'h00010000, 6'd11, 32'h0);
      issue(2'b00, 32'hFFFFFFFF, 32'h00000002, 6'd12, 32'hFFFFFFFE);
      issue(2'b01, 32'h80000000, 32'h80000000, 6'd13, 32'h40000000);
      issue(2'b11, 32'h80000000, 32'h00000002, 6'd14, 32'h00000001);
      issue(2'b01, 32'hFFFFFFFF, 32'h00000002, 6'd15, 32'hFFFFFFFF);
      idle(9);

      // streaming, one op per cycle, tags 0..15
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom;
         f = 2'($urandom_range(0, 3));
         issue(f, a, b, 6'(i), model(f, a, b));
      end
      idle(10);

      // reset mid-flight, with a start presented alongside reset
      issue(2'b00, 32'd10, 32'd10, 6'd20, 32'd100);
      issue(2'b11, 32'hFFFFFFFF, 32'd3, 6'd21, 32'd2);
      issue(2'b01, 32'hFFFFFFFF, 32'd3, 6'd22, 32'hFFFFFFFF);
      reset = 1'b1;
      issue(2'b00, 32'd5, 32'd5, 6'd23, 32'd25);
      check_cleared("mid_reset");
      reset = 1'b0;
      idle(10);
      issue(2'b00, 32'd7, 32'd6, 6'd24, 32'd42);
      idle(9);

`ifdef MULT_SQUASH_EN
      issue(2'b00, 32'd3, 32'd3, 6'd1, 32'd9);
      issue(2'b00, 32'd4, 32'd4, 6'd2, 32'd16);
      issue(2'b00, 32'd5, 32'd5, 6'd3, 32'd25);
      squash = 1'b1;
      issue(2'b00, 32'd6, 32'd6, 6'd4, 32'd36);
      squash = 1'b0;
      issue(2'b00, 32'd8, 32'd9, 6'd7, 32'd72);
      idle(9);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Parametrised, fully pipelined integer multiplier for the out-of-order core's multiply functional unit. It replaces the single-operation, start/done multiplier. It accepts one operation per cycle and covers all four RV32M multiply variants (MUL, MULH, MULHSU, MULHU). A destination tag travels with each operation so results can be broadcast on the CDB.

## Interface
Parameters:
- XLEN, 32: operand and result width.
- NUM_STAGES, 4: pipeline depth and result latency in cycles.
  - Must be ≥1 and must divide 2*XLEN.
- TAG_WIDTH, 6: width of the opaque tag carried with each operation.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all pipeline state.
- start  in  1  valid for a new operation this cycle.
- mcand  in  XLEN  multiplicand (rs1).
- mplier  in  XLEN  multiplier (rs2).
- func  in  2  operation select: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- tag_in  in  TAG_WIDTH  tag accompanying the operation.
- squash  in  1  kill all in-flight operations. Present only when MULT_SQUASH_EN is defined.
- done  out  1  product/tag_out valid this cycle.
- product  out  XLEN  selected half of the product.
- tag_out  out  TAG_WIDTH  tag of the completing operation.

## Operation
- Operand extension to 2*XLEN at acceptance:
  - mcand: sign-extended for MULH and MULHSU; zero-extended for MUL and MULHU.
  - mplier: sign-extended for MULH only; zero-extended otherwise.
- The product is the low 2*XLEN bits of extended mcand × extended mplier. All arithmetic is modulo 2^(2*XLEN).
- Each stage consumes 2*XLEN/NUM_STAGES bits of the extended multiplier, LSB first. Per stage:
  - add mcand × that chunk into the running partial sum;
  - shift the multiplicand left by the chunk width;
  - shift the multiplier right by the chunk width.
- Each stage register holds: valid, partial sum, shifted mcand, shifted mplier, func, tag.
- Output selection at the last stage:
  - func 00 returns bits [XLEN-1:0].
  - All other func values return bits [2*XLEN-1:XLEN].
- No stall input. The unit never backpressures and always accepts start. The consumer must accept done unconditionally.
- Operations complete strictly in issue order.

## Timing
- An op accepted at posedge N (start=1) shows done=1 with its product and tag_out after posedge N+NUM_STAGES, for exactly one cycle.
- done, product and tag_out are driven from registers, with no combinational path from the inputs.
- Back-to-back starts give done on consecutive cycles. Sustained throughput is 1 op/cycle.
- When done=0, product and tag_out hold their last values. They are don't-care to consumers.
- Reset:
  - All stage valid bits clear.
  - done=0, product=0, tag_out=0 on the cycle after the reset edge.
  - start asserted together with reset is dropped.
  - Reset mid-operation discards every in-flight op; no done is produced for them.
- Squash (when compiled in):
  - At the posedge where squash=1, all stage valid bits clear.
  - A start in the same cycle is also dropped.
  - done=0 in the following cycle.
  - A start on the cycle after squash is accepted normally.
- Boundary values:
  - mcand or mplier = 0 gives 0 for all funcs.
  - Overflow of the low half wraps silently.

## Configuration
- MULT_SQUASH_EN defined:
  - The squash port exists.
  - Branch-mispredict recovery kills all in-flight ops as described under Timing.
- MULT_SQUASH_EN undefined:
  - No squash port.
  - Only reset clears the pipeline. Every accepted op completes.

## Test plan
Default parameters (XLEN=32, NUM_STAGES=4) unless stated.
- Basic MUL: start with func=00, mcand=2, mplier=3, tag=5 → done exactly 4 cycles later, product=6, tag_out=5. done is low on every other cycle.
- Signed high halves: 0xFFFFFFFF × 0xFFFFFFFF:
  - MULH → 0x00000000
  - MULHU → 0xFFFFFFFE
  - MUL → 0x00000001
- MULHSU: mcand=0xFFFFFFFF, mplier=2 → 0xFFFFFFFF. mcand=0x80000000, mplier=0xFFFFFFFF → 0x80000000.
- Streaming: 16 random ops, one start per cycle, random func, tags 0..15 → 16 consecutive done cycles. Tags must come out 0..15 in order. Products must match a behavioural 64-bit reference per func. Repeat with NUM_STAGES=1, 2 and 8.
- Reset mid-flight: issue 3 ops, then assert reset one cycle after the third start → no done ever appears for those ops. An op started after reset deasserts completes normally 4 cycles later.
- Squash (MULT_SQUASH_EN defined):
  - Issue ops with tags 1, 2, 3 on consecutive cycles.
  - Assert squash together with a start for tag 4 → no done for tags 1–4.
  - A start for tag 7 on the next cycle produces done 4 cycles later with tag_out=7.
